// File: rtl/uc_sequencer_if.sv
// Bus bundle for the micro-sequencer: program load port, run control,
// external data input and the architectural outputs.
interface uc_sequencer_if #(
   parameter int DW    = 8,
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic          ena;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW+3:0] wr_data;
   logic          start;
   logic [DW-1:0] in_data;
   logic [DW-1:0] out_data;
   logic          carry;
   logic          busy;
   logic          done;
   logic [AW-1:0] pc;

   modport master (
      output ena, wr_en, wr_addr, wr_data, start, in_data,
      input  out_data, carry, busy, done, pc
   );

   modport slave (
      input  ena, wr_en, wr_addr, wr_data, start, in_data,
      output out_data, carry, busy, done, pc
   );
endinterface

// File: rtl/uc_sequencer.sv
// Tiny accumulator micro-sequencer: executes a writable program memory one
// instruction per cycle, with timed WAIT and HALT into a DONE state.
module uc_sequencer #(
   parameter int DW    = 8,
   parameter int DEPTH = 16
) (
   input  logic           clk,
   input  logic           rst,
   uc_sequencer_if.slave  seq
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [3:0] OP_LDI  = 4'd1;
   localparam logic [3:0] OP_ADDI = 4'd2;
   localparam logic [3:0] OP_SUBI = 4'd3;
   localparam logic [3:0] OP_IN   = 4'd4;
   localparam logic [3:0] OP_OUT  = 4'd5;
   localparam logic [3:0] OP_JMP  = 4'd6;
   localparam logic [3:0] OP_JNZ  = 4'd7;
   localparam logic [3:0] OP_WAIT = 4'd8;
   localparam logic [3:0] OP_HALT = 4'd9;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

   logic [DW+3:0] mem [DEPTH];

   state_t        state_q;
   logic [AW-1:0] pc_q, pc_d, pcInc;
   logic [DW-1:0] acc_q, acc_d;
   logic          carry_q, carry_d;
   logic [DW-1:0] outData_q;
   logic [DW-1:0] waitCnt_q;
   logic          busy_q, done_q;

   logic [DW+3:0] instr;
   logic [3:0]    opcode;
   logic [DW-1:0] operand;
   logic          memWrite;
   logic          waitTaken;

   assign instr     = mem[pc_q];
   assign opcode    = instr[DW+3:DW];
   assign operand   = instr[DW-1:0];
   assign pcInc     = pc_q + AW'(1);
   assign waitTaken = (opcode == OP_WAIT) && (operand != '0);
   assign memWrite  = seq.ena && seq.wr_en &&
                      ((state_q == S_IDLE) || (state_q == S_DONE));

   // Program memory is deliberately left out of reset so a reset can abort a
   // run without losing the loaded program.
   always_ff @(posedge clk) begin
      if (memWrite) begin
         mem[seq.wr_addr] <= seq.wr_data;
      end
   end

   always_comb begin
      acc_d   = acc_q;
      carry_d = carry_q;
      pc_d    = pcInc;
      case (opcode)
         OP_LDI:  acc_d = operand;
         OP_ADDI: {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, operand};
         OP_SUBI: begin
            acc_d   = acc_q - operand;
            carry_d = (operand > acc_q);
         end
         OP_IN:   acc_d = seq.in_data;
         OP_JMP:  pc_d = operand[AW-1:0];
         OP_JNZ:  if (acc_q != '0) pc_d = operand[AW-1:0];
         OP_WAIT: if (operand != '0) pc_d = pc_q;
         OP_HALT: pc_d = pc_q;
         default: ;
      endcase
   end

   // ena low freezes every register, so a paused WAIT resumes with the same
   // remaining count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         acc_q     <= '0;
         carry_q   <= 1'b0;
         outData_q <= '0;
         waitCnt_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else if (seq.ena) begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (seq.start) begin
                  state_q <= S_RUN;
                  pc_q    <= '0;
                  acc_q   <= '0;
                  carry_q <= 1'b0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            S_RUN: begin
               pc_q    <= pc_d;
               acc_q   <= acc_d;
               carry_q <= carry_d;
               if (opcode == OP_OUT) begin
                  outData_q <= acc_q;
               end
               if (waitTaken) begin
                  state_q   <= S_WAIT;
                  waitCnt_q <= operand;
               end else if (opcode == OP_HALT) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            S_WAIT: begin
               if (waitCnt_q == DW'(1)) begin
                  state_q   <= S_RUN;
                  waitCnt_q <= '0;
                  pc_q      <= pcInc;
               end else begin
                  waitCnt_q <= waitCnt_q - DW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign seq.out_data = outData_q;
   assign seq.carry    = carry_q;
   assign seq.busy     = busy_q;
   assign seq.done     = done_q;
   assign seq.pc       = pc_q;
endmodule
